// File: rtl/inst_fifo_pkg.sv
// Shared types for the dual-issue instruction queue.
package inst_fifo_pkg;

    // One queued fetch result: program counter plus instruction word.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    // Entries fetched and retired per cycle at most.
    localparam int FETCH_WIDTH = 2;

endpackage

// File: rtl/inst_fifo_mem.sv
// Entry storage for the instruction queue: two write ports, two async read ports.
// Write addresses are always distinct (tail and tail+1), so the ports never collide.
module inst_fifo_mem
    import inst_fifo_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_1,
    input  logic [AW-1:0] wa_1,
    input  fetch_entry_t  wd_1,
    input  logic          we_2,
    input  logic [AW-1:0] wa_2,
    input  fetch_entry_t  wd_2,
    input  logic [AW-1:0] ra_1,
    output fetch_entry_t  rd_1,
    input  logic [AW-1:0] ra_2,
    output fetch_entry_t  rd_2
);

    fetch_entry_t mem [DEPTH];

    // Storage is deliberately not reset; validity comes from the queue count.
    always_ff @(posedge clk) begin
        if (we_1) mem[wa_1] <= wd_1;
        if (we_2) mem[wa_2] <= wd_2;
    end

    assign rd_1 = mem[ra_1];
    assign rd_2 = mem[ra_2];

endmodule

// File: rtl/inst_fifo_dual.sv
// Dual-issue instruction queue between fetch and decode/issue.
// Takes up to two {pc, inst} pairs per cycle, presents the oldest two,
// retires 0/1/2 per cycle, and empties on flush.
module inst_fifo_dual
    import inst_fifo_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             wr_en_1,
    input  logic             wr_en_2,
    input  logic [WIDTH-1:0] wr_pc_1,
    input  logic [WIDTH-1:0] wr_inst_1,
    input  logic [WIDTH-1:0] wr_pc_2,
    input  logic [WIDTH-1:0] wr_inst_2,
    input  logic             rd_en_1,
    input  logic             rd_en_2,
    output logic             rd_valid_1,
    output logic             rd_valid_2,
    output logic [WIDTH-1:0] rd_pc_1,
    output logic [WIDTH-1:0] rd_inst_1,
    output logic [WIDTH-1:0] rd_pc_2,
    output logic [WIDTH-1:0] rd_inst_2,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    localparam int          NW       = $clog2(FETCH_WIDTH + 1);
    // Fewer than two free slots means a pair might not fit, so fetch stalls.
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH - 1);

    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW:0]   cnt;
    logic [NW-1:0] n_wr;
    logic [NW-1:0] n_rd;
    logic          wr_acc;
    logic          we_1;
    logic          we_2;
    fetch_entry_t  wd_1;
    fetch_entry_t  wd_2;
    fetch_entry_t  rd_e1;
    fetch_entry_t  rd_e2;

    assign count      = cnt;
    assign empty      = (cnt == '0);
    assign full       = (cnt >= CNT_FULL);
    assign rd_valid_1 = (cnt >= (AW+1)'(1));
    assign rd_valid_2 = (cnt >= (AW+1)'(2));

    // A pair is accepted or dropped as a unit; slot 2 alone is never written.
    assign wr_acc = !flush && !full;
    assign we_1   = wr_acc && wr_en_1;
    assign we_2   = wr_acc && wr_en_1 && wr_en_2;

    assign wd_1 = '{pc: 32'(wr_pc_1), inst: 32'(wr_inst_1)};
    assign wd_2 = '{pc: 32'(wr_pc_2), inst: 32'(wr_inst_2)};

    // Entry counts moved this cycle; retire only counts slots that are valid.
    always_comb begin
        n_wr = NW'({1'b0, we_1}) + NW'({1'b0, we_2});
        n_rd = '0;
        if (!flush) begin
            n_rd = NW'({1'b0, rd_en_1 && rd_valid_1})
                 + NW'({1'b0, rd_en_1 && rd_en_2 && rd_valid_2});
        end
    end

    inst_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk  (clk),
        .we_1 (we_1),
        .wa_1 (tail),
        .wd_1 (wd_1),
        .we_2 (we_2),
        .wa_2 (tail + AW'(1)),
        .wd_2 (wd_2),
        .ra_1 (head),
        .rd_1 (rd_e1),
        .ra_2 (head + AW'(1)),
        .rd_2 (rd_e2)
    );

    // Read data is masked to zero for invalid slots so stale storage never leaks out.
    always_comb begin
        rd_pc_1   = rd_valid_1 ? WIDTH'(rd_e1.pc)   : '0;
        rd_inst_1 = rd_valid_1 ? WIDTH'(rd_e1.inst) : '0;
        rd_pc_2   = rd_valid_2 ? WIDTH'(rd_e2.pc)   : '0;
        rd_inst_2 = rd_valid_2 ? WIDTH'(rd_e2.inst) : '0;
    end

    // Pointer and occupancy update; flush wins over any same-cycle traffic.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else if (flush) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            head <= head + AW'(n_rd);
            tail <= tail + AW'(n_wr);
            cnt  <= cnt + (AW+1)'(n_wr) - (AW+1)'(n_rd);
        end
    end

    a_count_bound: assert property (@(posedge clk) disable iff (!rst) cnt <= (AW+1)'(DEPTH));
    a_wr_pair:     assert property (@(posedge clk) disable iff (!rst) !(wr_en_2 && !wr_en_1));
    a_rd_pair:     assert property (@(posedge clk) disable iff (!rst) !(rd_en_2 && !rd_en_1));

endmodule
